// File: rtl/mem_stream_demux_if.sv
// Bundle of the merged-stream input and the demultiplexed write/status outputs
// of mem_stream_demux; master drives the stream, slave is the demux.
interface mem_stream_demux_if #(
  parameter int NMEM  = 12,
  parameter int DAT_W = 45,
  parameter int CNT_W = 6
);
  logic                    new_event;
  logic [2:0]              BX;
  logic [51:0]             mem_dat_stream;
  logic                    valid;
  logic                    none;
  logic [NMEM-1:0]         wr_en;
  logic [CNT_W+2:0]        wr_addr;
  logic [DAT_W-1:0]        wr_dat;
  logic [NMEM*CNT_W-1:0]   items;
  logic                    done;
  logic                    bx_err;
  logic                    ovf_err;
  logic                    idx_err;

  modport master (
    output new_event, BX, mem_dat_stream, valid, none,
    input  wr_en, wr_addr, wr_dat, items, done, bx_err, ovf_err, idx_err
  );

  modport slave (
    input  new_event, BX, mem_dat_stream, valid, none,
    output wr_en, wr_addr, wr_dat, items, done, bx_err, ovf_err, idx_err
  );
endinterface

// File: rtl/mem_stream_demux.sv
// Splits the merged 52-bit readout stream back into NMEM per-memory write ports.
// Define STREAM_BX_CHECK_EN to drop words whose BX tag differs from the event BX.
module mem_stream_demux #(
  parameter int NMEM  = 12,
  parameter int DAT_W = 45,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_stream_demux_if.slave  io
);

  typedef enum logic [1:0] {IDLE, HOLD, RECV, DONE} state_t;

  state_t               state, state_n;
  logic [1:0]           hold_cnt, hold_n;

  logic                 accept;
  logic                 s1_valid;
  logic [3:0]           s1_idx;
  logic [DAT_W-1:0]     s1_dat;
  logic [2:0]           evt_bx;
  logic [CNT_W-1:0]     cnt [NMEM];
  logic [CNT_W-1:0]     sel_cnt;
  logic                 idx_bad;
  logic                 bx_bad;
  logic                 write_ok;

  logic [NMEM-1:0]      wr_en_r;
  logic [CNT_W+2:0]     wr_addr_r;
  logic [DAT_W-1:0]     wr_dat_r;
  logic                 ovf_err_r;
  logic                 idx_err_r;
  logic [NMEM*CNT_W-1:0] items_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    if (io.new_event) begin
      state_n = HOLD;
      hold_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = IDLE;
        HOLD: begin
          if (hold_cnt == 2'd3) state_n = RECV;
          else                  hold_n  = hold_cnt + 2'd1;
        end
        RECV: if (io.none && !io.valid) state_n = DONE;
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // A word coincident with new_event belongs to the aborted event and is dropped.
  assign accept = io.valid && !io.new_event && (state != IDLE);

`ifdef STREAM_BX_CHECK_EN
  logic [2:0] s1_tag;
  logic       bx_err_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_dat   <= '0;
`ifdef STREAM_BX_CHECK_EN
      s1_tag   <= '0;
`endif
    end else begin
      s1_valid <= accept;
      s1_idx   <= io.mem_dat_stream[51:48];
      s1_dat   <= io.mem_dat_stream[DAT_W-1:0];
`ifdef STREAM_BX_CHECK_EN
      s1_tag   <= io.mem_dat_stream[47:45];
`endif
    end
  end

  always_comb begin
    sel_cnt = '0;
    idx_bad = 1'b1;
    for (int unsigned i = 0; i < NMEM; i++) begin
      if (32'(s1_idx) == i) begin
        sel_cnt = cnt[i];
        idx_bad = 1'b0;
      end
    end
  end

`ifdef STREAM_BX_CHECK_EN
  assign bx_bad = (s1_tag != evt_bx);
`else
  assign bx_bad = 1'b0;
`endif

  assign write_ok = s1_valid && !idx_bad && (sel_cnt != '1) && !bx_bad;

  // new_event also squashes the word already in the decode stage, so the
  // counters of the new event start from a clean zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_bx    <= '0;
      wr_en_r   <= '0;
      wr_addr_r <= '0;
      wr_dat_r  <= '0;
      ovf_err_r <= 1'b0;
      idx_err_r <= 1'b0;
      for (int unsigned i = 0; i < NMEM; i++) cnt[i] <= '0;
    end else begin
      wr_en_r <= '0;
      if (io.new_event) begin
        evt_bx    <= io.BX;
        ovf_err_r <= 1'b0;
        idx_err_r <= 1'b0;
        for (int unsigned i = 0; i < NMEM; i++) cnt[i] <= '0;
      end else if (s1_valid) begin
        if (idx_bad)              idx_err_r <= 1'b1;
        else if (sel_cnt == '1)   ovf_err_r <= 1'b1;
        if (write_ok) begin
          wr_addr_r <= {evt_bx, sel_cnt};
          wr_dat_r  <= s1_dat;
        end
        for (int unsigned i = 0; i < NMEM; i++) begin
          if (write_ok && (32'(s1_idx) == i)) begin
            wr_en_r[i] <= 1'b1;
            cnt[i]     <= sel_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef STREAM_BX_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       bx_err_r <= 1'b0;
    else if (io.new_event)                            bx_err_r <= 1'b0;
    else if (s1_valid && !idx_bad && sel_cnt != '1 && bx_bad) bx_err_r <= 1'b1;
  end
  assign io.bx_err = bx_err_r;
`else
  assign io.bx_err = 1'b0;
`endif

  always_comb begin
    items_w = '0;
    for (int unsigned i = 0; i < NMEM; i++) items_w[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign io.wr_en   = wr_en_r;
  assign io.wr_addr = wr_addr_r;
  assign io.wr_dat  = wr_dat_r;
  assign io.items   = items_w;
  assign io.done    = (state == DONE);
  assign io.ovf_err = ovf_err_r;
  assign io.idx_err = idx_err_r;

endmodule

// File: doc/mem_stream_demux.md
# mem_stream_demux

Receive-side counterpart of the memory readout merger. Takes the merged 52-bit word stream and its `valid` strobe from the far end of the link and splits it back into up to 12 per-memory write ports. Each destination gets its own write-address counter and item count. Sits at the input of the downstream processing board, ahead of the destination memories. It also recovers the per-event item counts and flags BX, overflow and index errors.

## Interface
- `NMEM`, 12, number of destination memories (max 16).
- `DAT_W`, 45, payload width.
- `CNT_W`, 6, per-memory address/count width.
- `clk`  in  1  processing clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `new_event`  in  1  single-cycle pulse; starts the next event.
- `BX`  in  3  BX of the incoming event; sampled when `new_event`=1.
- `mem_dat_stream`  in  52  stream word: [51:48] source index, [47:45] BX tag, [44:0] payload.
- `valid`  in  1  `mem_dat_stream` holds a valid word this cycle.
- `none`  in  1  sender has no more data.
- `wr_en`  out  NMEM  one-hot write strobe.
- `wr_addr`  out  CNT_W+3  {event BX, per-memory counter}.
- `wr_dat`  out  DAT_W  payload to write.
- `items`  out  NMEM*CNT_W  per-memory item counts, memory i at [i*CNT_W +: CNT_W].
- `done`  out  1  event fully received; held until next `new_event`.
- `bx_err`, `ovf_err`, `idx_err`  out  1 each  sticky per-event error flags.

## Operation
- **FSM IDLE → HOLD → RECV → DONE.** `new_event` in any state goes to HOLD.
- **`new_event` effects:**
  - latches `BX` into the event-BX register;
  - clears all counters, `items`, `done` and error flags on the next edge.
- **HOLD:** lasts 4 cycles, which covers the sender's 3-cycle setup plus its output register.
  - Words are still accepted in HOLD.
  - `none` is ignored in HOLD.
- **RECV:** each cycle with `valid`=1, decode index s = [51:48]:
  - s ≥ NMEM: drop the word, set `idx_err`.
  - counter[s] = 2^CNT_W−1: drop the word, set `ovf_err`. The counter saturates; it never wraps.
  - BX tag ≠ event BX (only when check compiled in): drop the word, set `bx_err`.
  - otherwise: write to memory s at address {eventBX, counter[s]}, then counter[s] += 1.
- **RECV → DONE:** when `none`=1 and `valid`=0 in the same cycle.
- **DONE:**
  - Late valid words are still written under the same rules and still increment counters.
  - `done` stays high.
- **Reset:** all state returns to IDLE immediately, mid-event included. Nothing is written in IDLE.
- **`valid` and `new_event` in the same cycle:** the word is dropped, because the new event takes priority.
- **`items`:** equals the live counters, so it matches the sender's `itemsxx` once `done` is high.

## Timing
- Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_dat`=0, `items`=0;
  - `done`=0, all error flags 0;
  - FSM in IDLE, event BX=0.
- Write latency: a word accepted on edge N appears on `wr_en`/`wr_addr`/`wr_dat` after edge N+1, for exactly one cycle.
- Counter and `items` update on the same edge as the write outputs.
- Error flags assert on edge N+1 after the offending word.
- `done` rises on the edge after the RECV→DONE condition.
- No backpressure: one word per cycle is accepted, back-to-back words are sustained, and `valid` may toggle freely.

## Configuration
- **`STREAM_BX_CHECK_EN` defined:** the BX tag is compared against the latched event BX; mismatches are dropped and set `bx_err`.
- **`STREAM_BX_CHECK_EN` undefined:** the BX tag is ignored, `bx_err` is tied to 0, and the comparator is not synthesized.

## Test plan
- **Basic demux:**
  - Stimulus: reset; `new_event` with BX=5; after 4 cycles send 3 words to index 2 and 1 word to index 7 (BX tag 5); then `none`=1.
  - Response: `wr_en`[2] pulses at addresses 0x140, 0x141, 0x142 and `wr_en`[7] at 0x140; `items`[2]=3, `items`[7]=1; `done`=1 one cycle after `none`.
- **Index error:**
  - Stimulus: word with index 13.
  - Response: no `wr_en`; `idx_err`=1; all counters unchanged.
- **Overflow:**
  - Stimulus: 65 words to index 0.
  - Response: 63 writes at addresses {BX, 0..62}; `items`[0]=63; `ovf_err` set after the 64th word; no further writes.
- **BX check (`STREAM_BX_CHECK_EN` defined):**
  - Stimulus: event BX=3, word with tag 4.
  - Response: dropped, `bx_err`=1.
  - Rebuild without the macro: the same word is written at {3, 0} and `bx_err`=0.
- **Abort and reset:**
  - Stimulus: `new_event` mid-RECV with 5 words outstanding, and one word coincident with the pulse.
  - Response: the coincident word is dropped; counters, `items` and flags read 0 on the next edge.
  - Then assert `rst_n`=0 asynchronously mid-burst: outputs clear without a clock edge.
